// File: rtl/mouse_master_sm.sv
// mouse_master_sm
// Master controller for a PS/2 mouse. It sits downstream of the byte
// receiver and alongside the byte transmitter. It runs the initialisation
// handshake (send 0xFF, expect FA/AA/00, send 0xF4, expect FA), then
// assembles 3-byte stream packets into STATUS/DX/DY and pulses
// SEND_INTERRUPT once per complete packet.
//
// Optional build feature: define MOUSE_SYNC_CHECK_EN to drop first-byte
// candidates whose bit3 is clear (out-of-sync guard). With the macro
// undefined, any error-free byte is accepted as packet byte 1.
//
// Handshake semantics (single-cycle pulses, no backpressure):
//   SEND_BYTE is high for exactly one cycle per command. BYTE_TO_SEND is
//   valid in that cycle and holds its value afterwards. The transmitter
//   answers with a one-cycle BYTE_SENT pulse. The receiver delivers each
//   byte with a one-cycle BYTE_READY pulse, qualified by BYTE_READ and
//   BYTE_ERROR_CODE in the same cycle. A pulse is consumed only in the
//   states that wait for it and is ignored everywhere else.
module mouse_master_sm #(
  parameter int POWERUP_WAIT = 5000000,
  parameter int RESP_TIMEOUT = 10000000,
  parameter int CNT_W        = 24
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       SEND_BYTE,
  output logic [7:0] BYTE_TO_SEND,
  input  logic       BYTE_SENT,
  output logic       READ_ENABLE,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_DX,
  output logic [7:0] MOUSE_DY,
  output logic       SEND_INTERRUPT,
  output logic       INIT_DONE,
  output logic [3:0] MASTER_STATE
);

  typedef enum logic [3:0] {
    PWR_WAIT   = 4'd0,
    SEND_FF    = 4'd1,
    WAIT_SENT1 = 4'd2,
    WAIT_ACK1  = 4'd3,
    WAIT_AA    = 4'd4,
    WAIT_ID    = 4'd5,
    SEND_F4    = 4'd6,
    WAIT_SENT2 = 4'd7,
    WAIT_ACK2  = 4'd8,
    STRM_B1    = 4'd9,
    STRM_B2    = 4'd10,
    STRM_B3    = 4'd11,
    PKT_OUT    = 4'd12
  } state_t;

  // Terminal counts; the counter reads 0 in the first cycle of a state.
  localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(POWERUP_WAIT - 1);
  localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESP_TIMEOUT - 1);

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_STREAM = 8'hF4;
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ID     = 8'h00;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic [7:0]       status_sh_q, status_sh_d;
  logic [7:0]       dx_sh_q, dx_sh_d;
  logic [7:0]       dy_sh_q, dy_sh_d;
  logic [7:0]       status_q, status_d;
  logic [7:0]       dx_q, dx_d;
  logic [7:0]       dy_q, dy_d;
  logic             irq_q, irq_d;

  logic             rx_ok;
  logic             resp_timeout;
  logic             sync_ok;

  assign rx_ok        = BYTE_READY && (BYTE_ERROR_CODE == 2'b00);
  assign resp_timeout = (cnt_q == RESP_LAST);

`ifdef MOUSE_SYNC_CHECK_EN
  // Byte 1 of every stream packet has bit3 set; anything else is a stray.
  assign sync_ok = BYTE_READ[3];
`else
  assign sync_ok = 1'b1;
`endif

  // Next-state, counter, command byte and packet register logic.
  always_comb begin
    state_d     = state_q;
    tx_byte_d   = tx_byte_q;
    status_sh_d = status_sh_q;
    dx_sh_d     = dx_sh_q;
    dy_sh_d     = dy_sh_q;
    status_d    = status_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    irq_d       = 1'b0;

    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          state_d   = SEND_FF;
          tx_byte_d = CMD_RESET;
        end
      end

      SEND_FF: state_d = WAIT_SENT1;

      WAIT_SENT1: begin
        if (BYTE_SENT)         state_d = WAIT_ACK1;
        else if (resp_timeout) state_d = PWR_WAIT;
      end

      WAIT_ACK1: begin
        if (BYTE_READY)        state_d = (rx_ok && BYTE_READ == RSP_ACK) ? WAIT_AA : PWR_WAIT;
        else if (resp_timeout) state_d = PWR_WAIT;
      end

      WAIT_AA: begin
        if (BYTE_READY)        state_d = (rx_ok && BYTE_READ == RSP_BAT_OK) ? WAIT_ID : PWR_WAIT;
        else if (resp_timeout) state_d = PWR_WAIT;
      end

      WAIT_ID: begin
        if (BYTE_READY) begin
          if (rx_ok && BYTE_READ == RSP_ID) begin
            state_d   = SEND_F4;
            tx_byte_d = CMD_STREAM;
          end else begin
            state_d = PWR_WAIT;
          end
        end else if (resp_timeout) begin
          state_d = PWR_WAIT;
        end
      end

      SEND_F4: state_d = WAIT_SENT2;

      WAIT_SENT2: begin
        if (BYTE_SENT)         state_d = WAIT_ACK2;
        else if (resp_timeout) state_d = PWR_WAIT;
      end

      WAIT_ACK2: begin
        if (BYTE_READY)        state_d = (rx_ok && BYTE_READ == RSP_ACK) ? STRM_B1 : PWR_WAIT;
        else if (resp_timeout) state_d = PWR_WAIT;
      end

      // A byte with a receive error restarts packet assembly from byte 1;
      // the visible packet registers are never touched by a partial packet.
      STRM_B1: begin
        if (rx_ok && sync_ok) begin
          status_sh_d = BYTE_READ;
          state_d     = STRM_B2;
        end
      end

      STRM_B2: begin
        if (BYTE_READY) begin
          if (rx_ok) begin
            dx_sh_d = BYTE_READ;
            state_d = STRM_B3;
          end else begin
            state_d = STRM_B1;
          end
        end
      end

      STRM_B3: begin
        if (BYTE_READY) begin
          if (rx_ok) begin
            dy_sh_d = BYTE_READ;
            state_d = PKT_OUT;
          end else begin
            state_d = STRM_B1;
          end
        end
      end

      // Publish the whole packet at once together with the interrupt.
      PKT_OUT: begin
        status_d = status_sh_q;
        dx_d     = dx_sh_q;
        dy_d     = dy_sh_q;
        irq_d    = 1'b1;
        state_d  = STRM_B1;
      end

      default: state_d = PWR_WAIT;
    endcase

    // The counter measures time spent in the current state only.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= '0;
      tx_byte_q   <= 8'h00;
      status_sh_q <= 8'h00;
      dx_sh_q     <= 8'h00;
      dy_sh_q     <= 8'h00;
      status_q    <= 8'h00;
      dx_q        <= 8'h00;
      dy_q        <= 8'h00;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tx_byte_q   <= tx_byte_d;
      status_sh_q <= status_sh_d;
      dx_sh_q     <= dx_sh_d;
      dy_sh_q     <= dy_sh_d;
      status_q    <= status_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      irq_q       <= irq_d;
    end
  end

  // Output decode from the registered state (glitch-free Moore outputs).
  always_comb begin
    SEND_BYTE   = (state_q == SEND_FF) || (state_q == SEND_F4);
    READ_ENABLE = 1'b0;
    INIT_DONE   = 1'b0;
    case (state_q)
      WAIT_ACK1, WAIT_AA, WAIT_ID, WAIT_ACK2,
      STRM_B1, STRM_B2, STRM_B3, PKT_OUT: READ_ENABLE = 1'b1;
      default:                            READ_ENABLE = 1'b0;
    endcase
    case (state_q)
      STRM_B1, STRM_B2, STRM_B3, PKT_OUT: INIT_DONE = 1'b1;
      default:                            INIT_DONE = 1'b0;
    endcase
  end

  assign BYTE_TO_SEND   = tx_byte_q;
  assign MOUSE_STATUS   = status_q;
  assign MOUSE_DX       = dx_q;
  assign MOUSE_DY       = dy_q;
  assign SEND_INTERRUPT = irq_q;
  assign MASTER_STATE   = state_q;

endmodule

// File: tb/tb_mouse_master_sm.sv
// Directed testbench for mouse_master_sm with short timing parameters.
module tb_mouse_master_sm;

  logic       CLK;
  logic       RESET;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;
  logic [7:0] MOUSE_STATUS;
  logic [7:0] MOUSE_DX;
  logic [7:0] MOUSE_DY;
  logic       SEND_INTERRUPT;
  logic       INIT_DONE;
  logic [3:0] MASTER_STATE;

  int errors = 0;
  int checks = 0;
  int irq_cnt = 0;
  logic [7:0] sent_q[$];

  mouse_master_sm #(
    .POWERUP_WAIT(10),
    .RESP_TIMEOUT(100),
    .CNT_W(24)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .SEND_BYTE(SEND_BYTE),
    .BYTE_TO_SEND(BYTE_TO_SEND),
    .BYTE_SENT(BYTE_SENT),
    .READ_ENABLE(READ_ENABLE),
    .BYTE_READ(BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
    .BYTE_READY(BYTE_READY),
    .MOUSE_STATUS(MOUSE_STATUS),
    .MOUSE_DX(MOUSE_DX),
    .MOUSE_DY(MOUSE_DY),
    .SEND_INTERRUPT(SEND_INTERRUPT),
    .INIT_DONE(INIT_DONE),
    .MASTER_STATE(MASTER_STATE)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Monitor on the falling edge: record command bytes and interrupts.
  always @(negedge CLK) begin
    if (SEND_BYTE) sent_q.push_back(BYTE_TO_SEND);
    if (SEND_INTERRUPT) irq_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic [1:0] e);
    BYTE_READ       = b;
    BYTE_ERROR_CODE = e;
    BYTE_READY      = 1'b1;
    tick();
    BYTE_READY      = 1'b0;
    BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic pulse_sent();
    BYTE_SENT = 1'b1;
    tick();
    BYTE_SENT = 1'b0;
  endtask

  // Count cycles until SEND_BYTE rises; bounded.
  task automatic wait_send(input string tag, input int exp_cycles, input logic [7:0] exp_byte);
    int n = 0;
    while (!SEND_BYTE && n < 500) begin
      tick();
      n++;
    end
    check({tag, "_cycles"}, n, exp_cycles);
    check({tag, "_byte"}, {24'h0, BYTE_TO_SEND}, {24'h0, exp_byte});
  endtask

  // Third byte already given; check 2-cycle latency and one-cycle pulse.
  task automatic expect_pkt(input string tag, input logic [7:0] s, input logic [7:0] x,
                            input logic [7:0] y);
    int irq0 = irq_cnt;
    check({tag, "_irq_early"}, {31'h0, SEND_INTERRUPT}, 32'd0);
    tick();
    check({tag, "_irq"}, {31'h0, SEND_INTERRUPT}, 32'd1);
    check({tag, "_out"}, {8'h0, MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, {8'h0, s, x, y});
    check({tag, "_state"}, {28'h0, MASTER_STATE}, 32'd9);
    tick();
    check({tag, "_irq_clr"}, {31'h0, SEND_INTERRUPT}, 32'd0);
    check({tag, "_irq_cnt"}, irq_cnt - irq0, 32'd1);
  endtask

  initial begin
    int n;
    RESET = 1'b1;
    BYTE_SENT = 1'b0;
    BYTE_READ = 8'h00;
    BYTE_ERROR_CODE = 2'b00;
    BYTE_READY = 1'b0;

    // Reset state
    do_reset();
    check("rst_state", {28'h0, MASTER_STATE}, 32'd0);
    check("rst_outs", {5'h0, SEND_BYTE, READ_ENABLE, INIT_DONE, SEND_INTERRUPT, 7'h0,
                       BYTE_TO_SEND, MOUSE_STATUS}, 32'd0);
    check("rst_dxdy", {16'h0, MOUSE_DX, MOUSE_DY}, 32'd0);
    // A byte while in PWR_WAIT is ignored
    send_rx(8'hFA, 2'b00);
    check("ign_pwr", {28'h0, MASTER_STATE}, 32'd0);

    // Full initialisation from a fresh reset
    do_reset();
    wait_send("init_ff", 10, 8'hFF);
    tick();
    check("ff_one_cycle", {31'h0, SEND_BYTE}, 32'd0);
    check("ff_held", {24'h0, BYTE_TO_SEND}, 32'hFF);
    check("st_sent1", {28'h0, MASTER_STATE}, 32'd2);
    send_rx(8'hFA, 2'b00);
    check("ign_sent1", {28'h0, MASTER_STATE}, 32'd2);
    pulse_sent();
    check("st_ack1", {28'h0, MASTER_STATE}, 32'd3);
    check("rden_ack1", {31'h0, READ_ENABLE}, 32'd1);
    send_rx(8'hFA, 2'b00);
    check("st_aa", {28'h0, MASTER_STATE}, 32'd4);
    send_rx(8'hAA, 2'b00);
    check("st_id", {28'h0, MASTER_STATE}, 32'd5);
    send_rx(8'h00, 2'b00);
    check("f4_send", {31'h0, SEND_BYTE}, 32'd1);
    check("f4_byte", {24'h0, BYTE_TO_SEND}, 32'hF4);
    tick();
    check("f4_one_cycle", {31'h0, SEND_BYTE}, 32'd0);
    pulse_sent();
    check("st_ack2", {28'h0, MASTER_STATE}, 32'd8);
    check("init_not_done", {31'h0, INIT_DONE}, 32'd0);
    send_rx(8'hFA, 2'b00);
    check("init_done", {31'h0, INIT_DONE}, 32'd1);
    check("st_b1", {28'h0, MASTER_STATE}, 32'd9);
    check("sent_cnt", sent_q.size(), 32'd2);
    if (sent_q.size() == 2) begin
      check("sent0", {24'h0, sent_q[0]}, 32'hFF);
      check("sent1", {24'h0, sent_q[1]}, 32'hF4);
    end

    // First packet
    send_rx(8'h09, 2'b00);
    send_rx(8'h05, 2'b00);
    send_rx(8'hFB, 2'b00);
    expect_pkt("pkt1", 8'h09, 8'h05, 8'hFB);

    // Receive error mid-packet discards the partial packet
    send_rx(8'h08, 2'b00);
    check("err_b2", {28'h0, MASTER_STATE}, 32'd10);
    send_rx(8'h33, 2'b01);
    check("err_back_b1", {28'h0, MASTER_STATE}, 32'd9);
    check("err_outs_kept", {8'h0, MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 32'h0009_05FB);
    send_rx(8'h18, 2'b00);
    send_rx(8'h01, 2'b00);
    send_rx(8'h02, 2'b00);
    expect_pkt("pkt2", 8'h18, 8'h01, 8'h02);

    // First-byte sync behaviour
`ifdef MOUSE_SYNC_CHECK_EN
    send_rx(8'h00, 2'b00);
    check("sync_drop", {28'h0, MASTER_STATE}, 32'd9);
    send_rx(8'h08, 2'b00);
    send_rx(8'h01, 2'b00);
    send_rx(8'h01, 2'b00);
    expect_pkt("pkt_sync", 8'h08, 8'h01, 8'h01);
`else
    send_rx(8'h00, 2'b00);
    check("nosync_accept", {28'h0, MASTER_STATE}, 32'd10);
    send_rx(8'h08, 2'b00);
    send_rx(8'h01, 2'b00);
    expect_pkt("pkt_nosync", 8'h00, 8'h08, 8'h01);
`endif

    // Reset in the middle of a packet
    send_rx(8'h28, 2'b00);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("midrst_state", {28'h0, MASTER_STATE}, 32'd0);
    check("midrst_outs", {8'h0, MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 32'd0);
    check("midrst_flags", {29'h0, INIT_DONE, READ_ENABLE, SEND_INTERRUPT}, 32'd0);
    check("midrst_tx", {24'h0, BYTE_TO_SEND}, 32'd0);

    // Bad reply in WAIT_ACK1 restarts the power-up wait
    wait_send("pre_fe", 10, 8'hFF);
    tick();
    pulse_sent();
    send_rx(8'hFE, 2'b00);
    check("fe_restart", {28'h0, MASTER_STATE}, 32'd0);
    wait_send("fe_resend", 10, 8'hFF);

    // Silence after 0xFF: timeout back to PWR_WAIT after 100 cycles
    tick();
    pulse_sent();
    n = 0;
    while (MASTER_STATE == 4'd3 && n < 500) begin
      tick();
      n++;
    end
    check("to_cycles", n, 32'd100);
    check("to_state", {28'h0, MASTER_STATE}, 32'd0);

    // Awaited byte on the last timeout cycle wins
    wait_send("pre_edge", 10, 8'hFF);
    tick();
    pulse_sent();
    repeat (99) tick();
    check("edge_still_ack1", {28'h0, MASTER_STATE}, 32'd3);
    send_rx(8'hFA, 2'b00);
    check("edge_event_wins", {28'h0, MASTER_STATE}, 32'd4);

    // Bad ID byte restarts as well
    send_rx(8'hAA, 2'b00);
    send_rx(8'h03, 2'b00);
    check("bad_id", {28'h0, MASTER_STATE}, 32'd0);
    check("irq_total", irq_cnt, 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mouse_master_sm.md
Name: mouse_master_sm

Overview:
- Master controller sitting directly downstream of the PS/2 mouse byte receiver and alongside the byte transmitter.
- Runs the PS/2 initialisation handshake: send 0xFF, expect 0xFA/0xAA/0x00, send 0xF4, expect 0xFA.
- Then assembles 3-byte stream packets into status/DX/DY registers and pulses an interrupt per complete packet.
- Feeds the mouse transceiver top level; consumed by the position/bus interface logic.

Parameters:
- POWERUP_WAIT, 5000000, cycles to wait after reset/restart before sending 0xFF (50 ms @100 MHz).
- RESP_TIMEOUT, 10000000, max cycles spent in any init wait state before a restart (100 ms @100 MHz).
- CNT_W, 24, counter width; must hold max(POWERUP_WAIT, RESP_TIMEOUT).

Ports:
- CLK input 1 system clock
- RESET input 1 synchronous, active-high
- SEND_BYTE output 1 one-cycle request to transmitter
- BYTE_TO_SEND output 8 command byte, valid while SEND_BYTE=1 and held afterwards
- BYTE_SENT input 1 transmitter done pulse
- READ_ENABLE output 1 enable to receiver
- BYTE_READ input 8 received byte
- BYTE_ERROR_CODE input 2 bit0 parity error, bit1 stop error
- BYTE_READY input 1 one-cycle receive-complete pulse
- MOUSE_STATUS output 8 packet byte 1
- MOUSE_DX output 8 packet byte 2
- MOUSE_DY output 8 packet byte 3
- SEND_INTERRUPT output 1 one-cycle pulse, new packet on outputs
- INIT_DONE output 1 high while in streaming states
- MASTER_STATE output 4 current state encoding (debug)

Behaviour:
- Reset: state=PWR_WAIT, counter=0, all outputs 0 (BYTE_TO_SEND=0x00, MOUSE_*=0x00).
- Single registered FSM. Counter clears on every state change and increments otherwise.
- READ_ENABLE=1 in all ACK/AA/ID/stream states, 0 elsewhere.
- PWR_WAIT(0): when counter==POWERUP_WAIT-1 -> SEND_FF.
- SEND_FF(1): SEND_BYTE=1 for exactly one cycle, BYTE_TO_SEND=0xFF -> WAIT_SENT1.
- WAIT_SENT1(2): BYTE_SENT -> WAIT_ACK1.
- WAIT_ACK1(3): on BYTE_READY, 0xFA with error 00 -> WAIT_AA; any other byte or error -> PWR_WAIT.
- WAIT_AA(4): on BYTE_READY, 0xAA with error 00 -> WAIT_ID; else -> PWR_WAIT.
- WAIT_ID(5): on BYTE_READY, 0x00 with error 00 -> SEND_F4; else -> PWR_WAIT.
- SEND_F4(6): one-cycle SEND_BYTE, BYTE_TO_SEND=0xF4 -> WAIT_SENT2.
- WAIT_SENT2(7): BYTE_SENT -> WAIT_ACK2.
- WAIT_ACK2(8): on BYTE_READY, 0xFA with error 00 -> STRM_B1; else -> PWR_WAIT.
- Timeout rule: in states 2,3,4,5,7,8, counter==RESP_TIMEOUT-1 without the awaited event -> PWR_WAIT. The awaited event wins over timeout in the same cycle.
- STRM_B1(9): on BYTE_READY with error 00, capture into internal status shadow -> STRM_B2.
- STRM_B2(10): on BYTE_READY with error 00, capture into DX shadow -> STRM_B3.
- STRM_B3(11): on BYTE_READY with error 00, capture into DY shadow -> PKT_OUT.
- Any BYTE_READY with nonzero error in states 9-11: discard the partial packet -> STRM_B1. Outputs are untouched.
- PKT_OUT(12): MOUSE_STATUS/DX/DY load from shadows; SEND_INTERRUPT=1 next cycle for exactly one cycle -> STRM_B1.
- Latency: SEND_INTERRUPT and updated MOUSE_* go high 2 cycles after the third BYTE_READY.
- No timeout in stream states. INIT_DONE=1 in states 9-12.
- BYTE_READY arriving in states 0,1,2,6,7 is ignored. BYTE_SENT outside states 2/7 is ignored.
- RESET mid-packet or mid-init: immediate return to reset values; the next cycle is PWR_WAIT.
- Unused encodings 13-15 -> PWR_WAIT.

Optional Feature:
- Macro MOUSE_SYNC_CHECK_EN.
- Defined: in STRM_B1, a byte with bit3==0 is treated as out of sync. It is dropped, the state stays STRM_B1, and nothing is captured.
- Undefined: any error-free byte is accepted as byte 1.

Test Plan:
- POWERUP_WAIT=10, RESP_TIMEOUT=100. Model replies FA, AA, 00 after 0xFF; FA after 0xF4 -> SEND_BYTE pulses with 0xFF then 0xF4; INIT_DONE=1 after the final FA.
- After init, feed bytes 0x09, 0x05, 0xFB -> MOUSE_STATUS=0x09, DX=0x05, DY=0xFB; a single one-cycle SEND_INTERRUPT 2 cycles after the 3rd BYTE_READY.
- During WAIT_ACK1, reply 0xFE -> returns to PWR_WAIT (MASTER_STATE=0) and 0xFF is resent after 10 cycles.
- No reply after 0xFF -> after 100 cycles in WAIT_ACK1, MASTER_STATE=0; no SEND_INTERRUPT.
- In stream: byte 0x08 ok, then byte with BYTE_ERROR_CODE=01 -> state STRM_B1, outputs unchanged. Then 0x18, 0x01, 0x02 -> outputs 0x18/0x01/0x02.
- With MOUSE_SYNC_CHECK_EN: feed 0x00 then 0x08, 0x01, 0x01 -> 0x00 dropped, packet 0x08/0x01/0x01. Also assert RESET mid-packet -> all outputs 0, MASTER_STATE=0.
